// File: rtl/dac_frame_sequencer_if.sv
// rtl/dac_frame_sequencer_if.sv - sample stream handshake into the DAC frame sequencer
// Signals: s_data (N-bit sample, MSB first on the serial line), s_valid, s_ready.
// Modports: master = sample source, slave = sequencer.
interface dac_frame_sequencer_if #(
    parameter int N = 12
) ();
    logic [N-1:0] s_data;
    logic         s_valid;
    logic         s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_frame_sequencer.sv
// rtl/dac_frame_sequencer.sv - paced serialiser feeding a 12-bit serial-input DAC
// Accepts samples into a one-entry holding buffer and, on every sample-rate tick,
// shifts the held word MSB-first on SI with SI_en high, then pulses soc for one cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   enable         run control; low holds the period counter at 0 (no ticks)
//   s              sample stream (slave modport: s_data, s_valid, s_ready)
//   SI, SI_en      serial data / shift enable to the DAC
//   soc            start-of-conversion pulse, one cycle per frame
//   busy           frame (shift or convert) in progress
//   underrun       one-cycle pulse when a tick finds the buffer empty
//   underrun_cnt   saturating count of underrun pulses
// Optional feature: define DAC_SEQ_REPEAT_ON_UNDERRUN_EN to replay the last word
// on an empty-buffer tick instead of skipping the frame.
module dac_frame_sequencer #(
    parameter int N      = 12,
    parameter int PERIOD = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    dac_frame_sequencer_if.slave  s,
    output logic                  SI,
    output logic                  SI_en,
    output logic                  soc,
    output logic                  busy,
    output logic                  underrun,
    output logic [7:0]            underrun_cnt
);
    localparam int          BW       = $clog2(N);
    localparam logic [15:0] CNT_LAST = 16'(PERIOD - 1);
    localparam logic [N-1:0] MID     = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SHIFT, CONV} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [15:0]    cnt;
    logic           tick;
    logic           buf_full;
    logic [N-1:0]   buf_data;
    logic [N-1:0]   shreg;
    logic [N-1:0]   last_word;
    logic [N-1:0]   shift_src;
    logic [BW-1:0]  bit_cnt;
    logic           take_buf;
    logic           load_shift;
    logic           underrun_evt;

    // Sample-rate pacing; gating tick with enable keeps a disabled cycle tick-free
    // even while the counter still shows its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tick = enable && (cnt == CNT_LAST);

    // Replay source is only selected when the buffer is empty.
    assign shift_src = buf_full ? buf_data : last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        take_buf     = 1'b0;
        load_shift   = 1'b0;
        underrun_evt = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    if (buf_full) begin
                        take_buf   = 1'b1;
                        load_shift = 1'b1;
                        state_nxt  = SHIFT;
                    end else begin
                        underrun_evt = 1'b1;
`ifdef DAC_SEQ_REPEAT_ON_UNDERRUN_EN
                        load_shift   = 1'b1;
                        state_nxt    = SHIFT;
`else
                        state_nxt    = IDLE;
`endif
                    end
                end
            end
            SHIFT: begin
                if (bit_cnt == BW'(N - 1)) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full     <= 1'b0;
            buf_data     <= '0;
            shreg        <= '0;
            last_word    <= MID;
            bit_cnt      <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            // Load only into an empty buffer, so load and consume never coincide.
            if (take_buf) begin
                buf_full <= 1'b0;
            end else if (s.s_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= s.s_data;
            end

            if (load_shift) begin
                shreg     <= shift_src;
                last_word <= shift_src;
                bit_cnt   <= '0;
            end else if (state == SHIFT) begin
                shreg   <= {shreg[N-2:0], 1'b0};
                bit_cnt <= bit_cnt + BW'(1);
            end

            underrun <= underrun_evt;
            if (underrun_evt && underrun_cnt != 8'hFF) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
        end
    end

    assign s.s_ready = !buf_full;
    assign SI_en     = (state == SHIFT);
    assign SI        = (state == SHIFT) && shreg[N-1];
    assign soc       = (state == CONV);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_dac_frame_sequencer.sv
// tb/tb_dac_frame_sequencer.sv - directed self-checking bench for dac_frame_sequencer
module tb_dac_frame_sequencer;
    localparam int N = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       SI, SI_en, soc, busy, underrun;
    logic [7:0] underrun_cnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dac_frame_sequencer_if #(.N(N)) sif ();

    dac_frame_sequencer #(.N(N), .PERIOD(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s            (sif),
        .SI           (SI),
        .SI_en        (SI_en),
        .soc          (soc),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    // Frame recorder: rebuilds each shifted word and notes its start cycle,
    // bit count and whether soc follows directly after the last bit.
    logic [N-1:0] q_word[$];
    int           q_start[$];
    int           q_nbits[$];
    bit           q_soc[$];
    int           soc_seen = 0;
    int           und_seen = 0;
    bit           in_frame = 0;
    logic [N-1:0] mw = '0;
    int           mnb = 0;
    int           mstart = 0;

    always @(negedge clk) begin
        if (soc) soc_seen++;
        if (underrun) und_seen++;
        if (SI_en) begin
            if (!in_frame) begin
                in_frame = 1;
                mnb = 0;
                mstart = cyc;
                mw = '0;
            end
            mw = {mw[N-2:0], SI};
            mnb++;
        end else if (in_frame) begin
            in_frame = 0;
            q_word.push_back(mw);
            q_start.push_back(mstart);
            q_nbits.push_back(mnb);
            q_soc.push_back(soc);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [N-1:0] x, output bit ok);
        sif.s_data  = x;
        sif.s_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (sif.s_ready) begin
                ok = 1;
                break;
            end
            step();
        end
        step();
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (q_word.size() >= n) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_si_en(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (SI_en) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; sif.s_valid = 1'b0; sif.s_data = '0;
        repeat (3) step();
        tests++; if (sif.s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b expected 1", sif.s_ready); end
        tests++; if (SI !== 1'b0) begin fails++; $display("FAIL reset_SI: got %b expected 0", SI); end
        tests++; if (SI_en !== 1'b0) begin fails++; $display("FAIL reset_SI_en: got %b expected 0", SI_en); end
        tests++; if (soc !== 1'b0) begin fails++; $display("FAIL reset_soc: got %b expected 0", soc); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        tests++; if (underrun_cnt !== 8'd0) begin fails++; $display("FAIL reset_underrun_cnt: got %0d expected 0", underrun_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_first_frame();
        int base, c, s0;
        bit ok;
        base = q_word.size();
        s0 = soc_seen;
        c = cyc;
        enable = 1'b1;
        sif.s_data = 12'hA5C;
        sif.s_valid = 1'b1;
        wait_frames(base + 2, ok);
        tests++; if (!ok) begin fails++; $display("FAIL first_frame_timeout: got %0d frames expected %0d", q_word.size() - base, 2); end
        if (ok) begin
            tests++; if (q_word[base] !== 12'hA5C) begin fails++; $display("FAIL first_word: got %h expected a5c", q_word[base]); end
            tests++; if (q_nbits[base] != 12) begin fails++; $display("FAIL first_si_en_len: got %0d expected 12", q_nbits[base]); end
            tests++; if (q_soc[base] !== 1'b1) begin fails++; $display("FAIL first_soc_follow: got %b expected 1", q_soc[base]); end
            tests++; if (q_start[base] != c + 32) begin fails++; $display("FAIL first_start_cycle: got %0d expected %0d", q_start[base], c + 32); end
            tests++; if (q_start[base+1] - q_start[base] != 32) begin fails++; $display("FAIL frame_spacing: got %0d expected 32", q_start[base+1] - q_start[base]); end
        end
        sif.s_valid = 1'b0;
        wait_frames(base + 3, ok);
        step();
        tests++; if (!ok || q_word[base+2] !== 12'hA5C) begin fails++; $display("FAIL third_word: got %h expected a5c", ok ? q_word[base+2] : 12'h0); end
        tests++; if (soc_seen - s0 != 3) begin fails++; $display("FAIL soc_pulses: got %0d expected 3", soc_seen - s0); end
    endtask

    task automatic test_stream();
        logic [N-1:0] words[3];
        int base;
        bit ok;
        words[0] = 12'h000; words[1] = 12'hFFF; words[2] = 12'h800;
        base = q_word.size();
        for (int i = 0; i < 3; i++) begin
            push(words[i], ok);
            tests++; if (!ok) begin fails++; $display("FAIL stream_push_%0d: got no handshake expected handshake", i); end
            tests++; if (sif.s_ready !== 1'b0) begin fails++; $display("FAIL stream_ready_low_%0d: got %b expected 0", i, sif.s_ready); end
        end
        wait_frames(base + 3, ok);
        tests++; if (!ok) begin fails++; $display("FAIL stream_timeout: got %0d frames expected 3", q_word.size() - base); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (q_word[base+i] !== words[i]) begin fails++; $display("FAIL stream_word_%0d: got %h expected %h", i, q_word[base+i], words[i]); end
                tests++; if (q_soc[base+i] !== 1'b1) begin fails++; $display("FAIL stream_soc_%0d: got %b expected 1", i, q_soc[base+i]); end
            end
            tests++; if (q_start[base+2] - q_start[base+1] != 32) begin fails++; $display("FAIL stream_spacing: got %0d expected 32", q_start[base+2] - q_start[base+1]); end
        end
        tests++; if (underrun_cnt !== 8'd0) begin fails++; $display("FAIL stream_no_underrun: got %0d expected 0", underrun_cnt); end
    endtask

    task automatic test_underrun();
        bit found = 0;
        bit activity = 0;
        int b;
        b = q_word.size();
        for (int i = 0; i < 100; i++) begin
            if (underrun) begin found = 1; break; end
            step();
        end
        tests++; if (!found) begin fails++; $display("FAIL underrun_pulse: got 0 expected 1"); end
        tests++; if (underrun_cnt !== 8'd1) begin fails++; $display("FAIL underrun_cnt_one: got %0d expected 1", underrun_cnt); end
`ifdef DAC_SEQ_REPEAT_ON_UNDERRUN_EN
        tests++; if (SI_en !== 1'b1) begin fails++; $display("FAIL repeat_si_en: got %b expected 1", SI_en); end
        step();
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL underrun_one_cycle: got %b expected 0", underrun); end
        wait_frames(b + 1, found);
        tests++; if (!found || q_word[b] !== 12'h800) begin fails++; $display("FAIL repeat_word: got %h expected 800", found ? q_word[b] : 12'h0); end
`else
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL underrun_busy: got %b expected 0", busy); end
        step();
        tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL underrun_one_cycle: got %b expected 0", underrun); end
        for (int i = 0; i < 14; i++) begin
            if (SI_en || soc || busy) activity = 1;
            step();
        end
        tests++; if (activity) begin fails++; $display("FAIL underrun_no_frame: got activity expected none"); end
        tests++; if (q_word.size() != b) begin fails++; $display("FAIL underrun_frames: got %0d expected %0d", q_word.size(), b); end
`endif
    endtask

    task automatic test_saturate();
        int u0;
        u0 = und_seen;
        repeat (300 * 32) step();
        tests++; if (underrun_cnt !== 8'd255) begin fails++; $display("FAIL saturate_cnt: got %0d expected 255", underrun_cnt); end
        tests++; if (und_seen - u0 < 299) begin fails++; $display("FAIL saturate_pulses: got %0d expected >=299", und_seen - u0); end
    endtask

    task automatic test_enable_drop();
        int b, c, u, s0;
        bit ok;
        push(12'h3C7, ok);
        wait_si_en(ok);
        tests++; if (!ok) begin fails++; $display("FAIL drop_frame_start: got no SI_en expected SI_en"); end
        b = q_word.size();
        repeat (5) step();
        enable = 1'b0;
        wait_frames(b + 1, ok);
        tests++; if (!ok || q_word[b] !== 12'h3C7) begin fails++; $display("FAIL drop_word: got %h expected 3c7", ok ? q_word[b] : 12'h0); end
        tests++; if (!ok || q_soc[b] !== 1'b1) begin fails++; $display("FAIL drop_soc: got %b expected 1", ok ? q_soc[b] : 1'b0); end
        step();
        u = und_seen; s0 = soc_seen; b = q_word.size();
        push(12'h123, ok);
        repeat (100) step();
        tests++; if (soc_seen != s0 || q_word.size() != b) begin fails++; $display("FAIL disabled_frames: got %0d expected 0", soc_seen - s0); end
        tests++; if (und_seen != u) begin fails++; $display("FAIL disabled_underrun: got %0d expected 0", und_seen - u); end
        tests++; if (sif.s_ready !== 1'b0) begin fails++; $display("FAIL disabled_buffer_held: got %b expected 0", sif.s_ready); end
        c = cyc;
        enable = 1'b1;
        wait_frames(b + 1, ok);
        tests++; if (!ok || q_start[b] != c + 32) begin fails++; $display("FAIL reenable_start: got %0d expected %0d", ok ? q_start[b] : -1, c + 32); end
        tests++; if (!ok || q_word[b] !== 12'h123) begin fails++; $display("FAIL reenable_word: got %h expected 123", ok ? q_word[b] : 12'h0); end
    endtask

    task automatic test_reset_mid();
        int s0;
        bit ok;
        push(12'h5A5, ok);
        wait_si_en(ok);
        tests++; if (!ok) begin fails++; $display("FAIL rstmid_frame_start: got no SI_en expected SI_en"); end
        repeat (3) step();
        s0 = soc_seen;
        rst = 1'b1;
        enable = 1'b0;
        step();
        tests++; if (SI_en !== 1'b0) begin fails++; $display("FAIL rstmid_si_en: got %b expected 0", SI_en); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        tests++; if (sif.s_ready !== 1'b1) begin fails++; $display("FAIL rstmid_s_ready: got %b expected 1", sif.s_ready); end
        tests++; if (underrun_cnt !== 8'd0) begin fails++; $display("FAIL rstmid_cnt: got %0d expected 0", underrun_cnt); end
        rst = 1'b0;
        repeat (30) step();
        tests++; if (soc_seen != s0) begin fails++; $display("FAIL rstmid_no_soc: got %0d expected 0", soc_seen - s0); end
    endtask

    initial begin
        sif.s_data = '0;
        sif.s_valid = 1'b0;
        test_reset();
        test_first_frame();
        test_stream();
        test_underrun();
        test_saturate();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
